phase_period_meter: RTL and testbench

Parametrised two-channel encoder timing meter that measures the phase offset between the rising edges of enc_a and enc_b. It reports which channel leads, and also measures the enc_a period, all in clk cycles. It adds features the single-direction phase counter lacks:
- input synchronisers
- signed lead reporting
- saturation and timeout flags
- valid strobes
- a synchronous clear
It sits between the encoder pins and the motor-control/status register logic.

---
 rtl/phase_meter_pkg.sv | 20 ++
 rtl/enc_edge_sync.sv | 38 +++
 rtl/phase_period_meter.sv | 167 ++++++++++++++++
 tb/tb_phase_period_meter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_meter_pkg.sv
// Shared types and helpers for the two-channel encoder phase/period meter.
package phase_meter_pkg;

    // Phase measurement FSM: idle, or counting after an A-first / B-first edge
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CNT_AB = 2'd1,
        CNT_BA = 2'd2
    } phase_state_t;

    // Increment value, saturating at the all-ones pattern of the given width.
    // Works on a 32-bit carrier so callers of any width up to 32 can share it.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned  width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : (value + 32'd1);
    endfunction

endpackage

// File: rtl/enc_edge_sync.sv
// Synchroniser chain plus rising-edge detector for one asynchronous encoder pin.
module enc_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic pin,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    // Shifts in ones after reset/clear; the edge output is enabled only once
    // the history flop has captured a genuine synchronised sample, so a line
    // that is already high when reset/clear drops is not reported as an edge.
    logic [SYNC_STAGES:0]   fill;

    // Synchroniser, history flop and post-clear settling tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
            fill <= '0;
        end else if (clr) begin
            sync <= '0;
            hist <= 1'b0;
            fill <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            hist <= sync[SYNC_STAGES-1];
            fill <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~hist & fill[SYNC_STAGES];

endmodule

// File: rtl/phase_period_meter.sv
// Two-channel encoder timing meter: signed A/B phase offset and A period,
// both in clk cycles, with saturation/timeout flags and 1-cycle valid strobes.
module phase_period_meter
    import phase_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [CNT_W-1:0] phase_cnt,
    output logic             lead_a,
    output logic             phase_valid,
    output logic             phase_ovf,
    output logic [CNT_W-1:0] period_cnt,
    output logic             period_valid,
    output logic             period_ovf
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             rise_a;
    logic             rise_b;
    phase_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per;
    logic             seen_a;

    enc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .pin   (enc_a),
        .rise  (rise_a)
    );

    enc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .pin   (enc_b),
        .rise  (rise_b)
    );

    // Phase FSM: count from the leading edge to the lagging edge, or time out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            phase_cnt   <= '0;
            lead_a      <= 1'b0;
            phase_valid <= 1'b0;
            phase_ovf   <= 1'b0;
        end else if (clr) begin
            state       <= IDLE;
            cnt         <= '0;
            phase_cnt   <= '0;
            lead_a      <= 1'b0;
            phase_valid <= 1'b0;
            phase_ovf   <= 1'b0;
        end else begin
            phase_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise_a && rise_b) begin
                        // Coincident edges: zero offset, reported as A leading
                        phase_cnt   <= '0;
                        lead_a      <= 1'b1;
                        phase_ovf   <= 1'b0;
                        phase_valid <= 1'b1;
                    end else if (rise_a) begin
                        cnt   <= ONE;
                        state <= CNT_AB;
                    end else if (rise_b) begin
                        cnt   <= ONE;
                        state <= CNT_BA;
                    end
                end
                CNT_AB: begin
                    if (rise_b) begin
                        phase_cnt   <= cnt;
                        lead_a      <= 1'b1;
                        phase_ovf   <= 1'b0;
                        phase_valid <= 1'b1;
                        if (rise_a) begin
                            cnt <= ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (rise_a) begin
                        // A repeated before B arrived: measure from the newest A
                        cnt <= ONE;
                    end else if (cnt == MAX) begin
                        phase_cnt   <= MAX;
                        lead_a      <= 1'b1;
                        phase_ovf   <= 1'b1;
                        phase_valid <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
                    end
                end
                CNT_BA: begin
                    if (rise_a) begin
                        phase_cnt   <= cnt;
                        lead_a      <= 1'b0;
                        phase_ovf   <= 1'b0;
                        phase_valid <= 1'b1;
                        if (rise_b) begin
                            cnt <= ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (rise_b) begin
                        cnt <= ONE;
                    end else if (cnt == MAX) begin
                        phase_cnt   <= MAX;
                        lead_a      <= 1'b0;
                        phase_ovf   <= 1'b1;
                        phase_valid <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Period counter: A-to-A interval, saturating, first edge only arms it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_a       <= 1'b0;
            per          <= '0;
            period_cnt   <= '0;
            period_valid <= 1'b0;
            period_ovf   <= 1'b0;
        end else if (clr) begin
            seen_a       <= 1'b0;
            per          <= '0;
            period_cnt   <= '0;
            period_valid <= 1'b0;
            period_ovf   <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (rise_a) begin
                per    <= ONE;
                seen_a <= 1'b1;
                if (seen_a) begin
                    period_cnt   <= per;
                    period_ovf   <= (per == MAX);
                    period_valid <= 1'b1;
                end
            end else if (seen_a) begin
                per <= CNT_W'(sat_inc(32'(per), CNT_W));
            end
        end
    end

endmodule

// File: tb/tb_phase_period_meter.sv
// Scoreboard bench for phase_period_meter (CNT_W=8, SYNC_STAGES=2).
module tb_phase_period_meter;

    localparam int CNT_W = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr   = 1'b0;
    logic             enc_a = 1'b0;
    logic             enc_b = 1'b0;
    logic [CNT_W-1:0] phase_cnt;
    logic             lead_a;
    logic             phase_valid;
    logic             phase_ovf;
    logic [CNT_W-1:0] period_cnt;
    logic             period_valid;
    logic             period_ovf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int cnt;
        int lead;
        int ovf;
        int at;
    } ph_exp_t;

    typedef struct {
        int cnt;
        int ovf;
    } per_exp_t;

    ph_exp_t  ph_q[$];
    per_exp_t per_q[$];

    phase_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .phase_cnt    (phase_cnt),
        .lead_a       (lead_a),
        .phase_valid  (phase_valid),
        .phase_ovf    (phase_ovf),
        .period_cnt   (period_cnt),
        .period_valid (period_valid),
        .period_ovf   (period_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT strobes a result
    always @(negedge clk) begin
        ph_exp_t  pe;
        per_exp_t qe;
        if (rst_n) begin
            if (phase_valid) begin
                if (ph_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_phase_strobe: got cnt=%0d lead_a=%0d ovf=%0d, expected no strobe",
                             phase_cnt, lead_a, phase_ovf);
                end else begin
                    pe = ph_q.pop_front();
                    check("phase_cnt", int'(phase_cnt), pe.cnt);
                    check("lead_a", int'(lead_a), pe.lead);
                    check("phase_ovf", int'(phase_ovf), pe.ovf);
                    if (pe.at >= 0) check("phase_strobe_cycle", cyc, pe.at);
                end
            end
            if (period_valid) begin
                if (per_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_period_strobe: got cnt=%0d ovf=%0d, expected no strobe",
                             period_cnt, period_ovf);
                end else begin
                    qe = per_q.pop_front();
                    check("period_cnt", int'(period_cnt), qe.cnt);
                    check("period_ovf", int'(period_ovf), qe.ovf);
                end
            end
        end
    end

    // Advance n clocks, landing 2 time units after the active edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_ph(input int c, input int l, input int o, input int at);
        ph_exp_t e;
        e.cnt = c; e.lead = l; e.ovf = o; e.at = at;
        ph_q.push_back(e);
    endtask

    task automatic push_per(input int c, input int o);
        per_exp_t e;
        e.cnt = c; e.ovf = o;
        per_q.push_back(e);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(4);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((ph_q.size() != 0 || per_q.size() != 0) && n < 2000) begin
            step(1);
            n++;
        end
        checks++;
        if (ph_q.size() != 0 || per_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d phase and %0d period results still pending, expected 0",
                     name, ph_q.size(), per_q.size());
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase_cnt"}, int'(phase_cnt), 0);
        check({tag, "_lead_a"}, int'(lead_a), 0);
        check({tag, "_phase_valid"}, int'(phase_valid), 0);
        check({tag, "_phase_ovf"}, int'(phase_ovf), 0);
        check({tag, "_period_cnt"}, int'(period_cnt), 0);
        check({tag, "_period_valid"}, int'(period_valid), 0);
        check({tag, "_period_ovf"}, int'(period_ovf), 0);
    endtask

    initial begin
        int t;

        // Reset state
        step(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        step(4);

        // 1: A leads B by 10; strobe 3 cycles after the B pin edge
        do_clr();
        enc_a = 1'b1;
        step(10);
        enc_b = 1'b1;
        push_ph(10, 1, 0, cyc + 3);
        drain("s1_drain");
        enc_a = 1'b0; enc_b = 1'b0;
        step(5);

        // 2: B leads A by 5
        do_clr();
        enc_b = 1'b1;
        step(5);
        enc_a = 1'b1;
        push_ph(5, 0, 0, cyc + 3);
        drain("s2_drain");
        enc_a = 1'b0; enc_b = 1'b0;
        step(5);

        // 3a: coincident edges
        do_clr();
        enc_a = 1'b1; enc_b = 1'b1;
        push_ph(0, 1, 0, cyc + 3);
        drain("s3a_drain");
        enc_a = 1'b0; enc_b = 1'b0;
        step(5);

        // 3b: A re-arms at +3, B at +7 -> offset 4; A period of 3
        do_clr();
        enc_a = 1'b1;
        step(1);
        enc_a = 1'b0;
        step(2);
        enc_a = 1'b1;
        push_per(3, 0);
        step(4);
        enc_b = 1'b1;
        push_ph(4, 1, 0, -1);
        drain("s3b_drain");
        enc_a = 1'b0; enc_b = 1'b0;
        step(5);

        // 4: phase timeout, then B-first measurement; A period saturates
        do_clr();
        enc_a = 1'b1;
        t = cyc;
        push_ph(255, 1, 1, t + 258);
        step(100);
        enc_a = 1'b0;
        step(200);
        enc_b = 1'b1;
        step(6);
        enc_a = 1'b1;
        push_ph(6, 0, 0, -1);
        push_per(255, 1);
        drain("s4_drain");
        enc_a = 1'b0; enc_b = 1'b0;
        step(5);

        // 5: A period 40 x3, then a 400-cycle gap
        do_clr();
        for (int i = 0; i < 4; i++) begin
            enc_a = 1'b1;
            if (i > 0) push_per(40, 0);
            step(20);
            enc_a = 1'b0;
            step(20);
        end
        push_ph(255, 1, 1, -1);
        step(360);
        enc_a = 1'b1;
        push_per(255, 1);
        push_ph(255, 1, 1, -1);
        step(20);
        enc_a = 1'b0;
        step(300);
        drain("s5_drain");

        // 6a: reset while counting with enc_a held high
        enc_a = 1'b1;
        push_per(255, 1);
        step(23);
        rst_n = 1'b0;
        step(1);
        check_all_zero("async_reset");
        step(2);
        rst_n = 1'b1;
        step(10);
        enc_b = 1'b1;
        step(2);
        enc_a = 1'b0;
        step(2);
        enc_a = 1'b1;
        push_ph(4, 0, 0, -1);
        drain("s6a_drain");
        step(5);

        // 6b: clear mid-count with both lines high
        enc_b = 1'b0;
        step(3);
        enc_b = 1'b1;
        step(20);
        clr = 1'b1;
        step(1);
        check_all_zero("sync_clear");
        clr = 1'b0;
        step(10);
        enc_a = 1'b0; enc_b = 1'b0;
        step(3);
        enc_b = 1'b1;
        step(3);
        enc_a = 1'b1;
        push_ph(3, 0, 0, -1);
        drain("s6b_drain");
        step(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
